serial_rx: RTL and testbench

- UART receiver, 8N1 framing, LSB first, idle-high line; the receive-side counterpart of the team's 8N1 UART transmitter.
- Oversamples the asynchronous rx line and synchronizes it, then validates start and stop bits.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board UART RX pin and downstream logic (byte FIFO, display, command decoder).

---
 rtl/serial_rx.sv | 135 +++++++++++++
 tb/tb_serial_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver (LSB first, idle-high line).
// The rx pin is synchronized and start/stop bits are validated at mid-bit.
// Each good byte is presented on val_out with a one-cycle valid_out strobe.
// A low stop bit gives a one-cycle frame_err_out pulse instead.
module serial_rx #(
    parameter int DIVISOR     = 868,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       data_in,
    output logic [7:0] val_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       busy_out
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;
    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             idx_r;
    logic [7:0]             shift_r;
    // Set once a high line has been seen, so a low line after reset or a
    // break after a framing error is never mistaken for a start edge.
    logic                   armed_r;

    assign rx_s = sync_r[SYNC_STAGES-1];

    // Input synchronizer chain; preset high so reset looks like an idle line.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], data_in};
        end
    end

    // Receive FSM: start detection, mid-bit sampling, byte assembly and flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            idx_r         <= 3'd0;
            shift_r       <= 8'h00;
            armed_r       <= 1'b0;
            val_out       <= 8'h00;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (armed_r && !rx_s) begin
                        state_r  <= ST_START;
                        cnt_r    <= '0;
                        busy_out <= 1'b1;
                        armed_r  <= 1'b0;
                    end else begin
                        armed_r  <= armed_r | rx_s;
                    end
                end
                ST_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= '0;
                        if (rx_s) begin
                            // Start bit gone at mid-bit: glitch, drop it silently.
                            state_r  <= ST_IDLE;
                            busy_out <= 1'b0;
                            armed_r  <= 1'b1;
                        end else begin
                            state_r <= ST_DATA;
                            idx_r   <= 3'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r          <= '0;
                        shift_r[idx_r] <= rx_s;
                        if (idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r    <= '0;
                        state_r  <= ST_IDLE;
                        busy_out <= 1'b0;
                        if (rx_s) begin
                            val_out   <= shift_r;
                            valid_out <= 1'b1;
                            // Stop bit already proves the line high, so a
                            // back-to-back start edge is caught straight away.
                            armed_r   <= 1'b1;
                        end else begin
                            frame_err_out <= 1'b1;
                            armed_r       <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= '0;
                    idx_r    <= 3'd0;
                    busy_out <= 1'b0;
                    armed_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: scoreboard of expected bytes/errors,
// a fast-divisor instance for the functional scenarios and a full-rate
// instance for the latency check.
module tb_serial_rx;

    localparam int DIV     = 96;
    localparam int BIG_DIV = 868;
    localparam int SYNC    = 2;
    localparam int BIG_LAT = (19 * BIG_DIV) / 2 + SYNC + 2;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       line = 1'b1;
    logic       line_big = 1'b1;
    logic [7:0] val_out;
    logic       valid_out, frame_err_out, busy_out;
    logic [7:0] big_val;
    logic       big_valid, big_ferr, big_busy;

    exp_t       exp_q[$];
    logic [7:0] model_val = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         big_cnt = 0;
    int         big_ferr_cnt = 0;
    int         big_t = 0;
    logic [7:0] big_cap = 8'h00;

    serial_rx #(.DIVISOR(DIV), .SYNC_STAGES(SYNC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(line),
        .val_out(val_out), .valid_out(valid_out),
        .frame_err_out(frame_err_out), .busy_out(busy_out)
    );

    serial_rx #(.DIVISOR(BIG_DIV), .SYNC_STAGES(SYNC)) dut_big (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(line_big),
        .val_out(big_val), .valid_out(big_valid),
        .frame_err_out(big_ferr), .busy_out(big_busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic drive_bit(input logic v, input int cycles, input bit big);
        if (big) line_big = v;
        else     line = v;
        repeat (cycles) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int period,
                              input logic stop_v, input bit big);
        drive_bit(1'b0, period, big);
        for (int i = 0; i < 8; i++) drive_bit(b[i], period, big);
        drive_bit(stop_v, period, big);
    endtask

    task automatic push_exp(input bit is_err, input logic [7:0] b);
        exp_t e;
        e.is_err = is_err;
        e.data   = is_err ? model_val : b;
        if (!is_err) model_val = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_in);
            n++;
        end
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: pending=%0d expected=0", tag, exp_q.size());
        end
    endtask

    // Observes both DUTs on the falling edge and pops the scoreboard.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (big_valid) begin
                big_cnt++;
                big_cap = big_val;
                big_t   = cyc;
            end
            if (big_ferr) big_ferr_cnt++;
            if (!rst_in && (valid_out || frame_err_out)) begin
                checks++;
                assert (!(valid_out && frame_err_out)) else begin
                    errors++;
                    $error("FAIL excl: valid=%b ferr=%b expected not both", valid_out, frame_err_out);
                end
                checks++;
                assert (busy_out === 1'b0) else begin
                    errors++;
                    $error("FAIL busy_at_pulse: observed=%b expected=0", busy_out);
                end
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious: valid=%b ferr=%b val=%h expected no pulse",
                           valid_out, frame_err_out, val_out);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (frame_err_out === e.is_err) else begin
                        errors++;
                        $error("FAIL kind: ferr observed=%b expected=%b", frame_err_out, e.is_err);
                    end
                    checks++;
                    assert (val_out === e.data) else begin
                        errors++;
                        $error("FAIL data: observed=%h expected=%h", val_out, e.data);
                    end
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        assert (val_out === model_val && valid_out === 1'b0 &&
                frame_err_out === 1'b0 && busy_out === 1'b0) else begin
            errors++;
            $error("FAIL %s: val=%h valid=%b ferr=%b busy=%b expected val=%h 0 0 0",
                   tag, val_out, valid_out, frame_err_out, busy_out, model_val);
        end
    endtask

    initial begin
        int c0;
        fork
            monitor_loop();
        join_none

        // Reset state.
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        check_idle_outputs("reset");
        checks++;
        assert (big_val === 8'h00 && big_valid === 1'b0 && big_busy === 1'b0) else begin
            errors++;
            $error("FAIL reset_big: val=%h valid=%b busy=%b expected 00 0 0", big_val, big_valid, big_busy);
        end
        @(posedge clk_in); #1;
        drive_bit(1'b1, 4, 1'b0);

        // Full-rate 0xA5: value and latency from the start edge.
        c0 = cyc;
        send_frame(8'hA5, BIG_DIV, 1'b1, 1'b1);
        drive_bit(1'b1, BIG_DIV, 1'b1);
        checks++;
        assert (big_cnt == 1 && big_cap === 8'hA5 && big_ferr_cnt == 0) else begin
            errors++;
            $error("FAIL big_a5: pulses=%0d val=%h ferr=%0d expected 1 a5 0", big_cnt, big_cap, big_ferr_cnt);
        end
        checks++;
        assert ((big_t - c0) >= BIG_LAT - 2 && (big_t - c0) <= BIG_LAT + 2) else begin
            errors++;
            $error("FAIL latency: observed=%0d expected=%0d+-2", big_t - c0, BIG_LAT);
        end

        // Framing error with a 20-bit break, then a good byte; val stays at reset value.
        push_exp(1'b1, 8'h3C);
        send_frame(8'h3C, DIV, 1'b0, 1'b0);
        drive_bit(1'b0, 20 * DIV, 1'b0);
        wait_drain(1, "ferr_seen");
        checks++;
        assert (busy_out === 1'b0 && val_out === 8'h00) else begin
            errors++;
            $error("FAIL break: busy=%b val=%h expected 0 00", busy_out, val_out);
        end
        drive_bit(1'b1, DIV, 1'b0);
        push_exp(1'b0, 8'h81);
        send_frame(8'h81, DIV, 1'b1, 1'b0);
        wait_drain(4 * DIV, "after_break");

        // Back-to-back frames, no idle gap.
        push_exp(1'b0, 8'h00);
        send_frame(8'h00, DIV, 1'b1, 1'b0);
        push_exp(1'b0, 8'hFF);
        send_frame(8'hFF, DIV, 1'b1, 1'b0);
        push_exp(1'b0, 8'h55);
        send_frame(8'h55, DIV, 1'b1, 1'b0);
        wait_drain(4 * DIV, "b2b");

        // Short low glitch: busy rises, then drops with no pulse.
        drive_bit(1'b0, 20, 1'b0);
        checks++;
        assert (busy_out === 1'b1) else begin
            errors++;
            $error("FAIL glitch_busy: observed=%b expected=1", busy_out);
        end
        drive_bit(1'b1, 2 * DIV, 1'b0);
        check_idle_outputs("glitch_idle");

        // Reset in the middle of bit 4 (line low), then a clean frame.
        send_frame_partial: begin
            drive_bit(1'b0, DIV, 1'b0);
            for (int i = 0; i < 4; i++) drive_bit(1'b1, DIV, 1'b0);
            drive_bit(1'b0, DIV / 2, 1'b0);
            rst_in = 1'b1;
            model_val = 8'h00;
            repeat (2) @(posedge clk_in);
            #1 rst_in = 1'b0;
            drive_bit(1'b0, 10, 1'b0);
            drive_bit(1'b1, 2 * DIV, 1'b0);
        end
        check_idle_outputs("abort");
        push_exp(1'b0, 8'h7E);
        send_frame(8'h7E, DIV, 1'b1, 1'b0);
        wait_drain(4 * DIV, "after_abort");

        // Bit period 2% fast, then 2% slow.
        push_exp(1'b0, 8'hC3);
        send_frame(8'hC3, (DIV * 98) / 100, 1'b1, 1'b0);
        drive_bit(1'b1, DIV, 1'b0);
        wait_drain(4 * DIV, "fast");
        push_exp(1'b0, 8'hC3);
        send_frame(8'hC3, (DIV * 102 + 50) / 100, 1'b1, 1'b0);
        drive_bit(1'b1, DIV, 1'b0);
        wait_drain(4 * DIV, "slow");
        check_idle_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
